// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer: FSM states,
// FIFO entry layout and the {d_plus,d_minus} line encodings.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  typedef struct packed {
    logic       is_eop;
    logic [7:0] data;
  } tx_entry_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int STUFF_LIMIT  = 6;
  localparam int EOP_SE0_BITS = 2;

  // Differential pair for an NRZI level held as "line is J".
  function automatic logic [1:0] nrzi_line(input logic is_j);
    return is_j ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// DEPTH x 9 synchronous FIFO with two ordered push ports (byte before EOP),
// full/empty flags and a sticky overflow flag for dropped pushes.
module tx_byte_fifo
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_a,
  input  tx_entry_t entry_a,
  input  logic      push_b,
  input  tx_entry_t entry_b,
  input  logic      pop,
  output tx_entry_t head,
  output logic      empty,
  output logic      full,
  output logic      overflow
);

  localparam int AW = $clog2(DEPTH);

  tx_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    lvl0, lvl1;
  logic           do_pop, acc_a, acc_b, drop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // Each push sees the occupancy left by the pop and by any earlier push.
  always_comb begin
    do_pop = pop & ~empty;
    lvl0   = count - (AW+1)'(do_pop);
    acc_a  = push_a & (lvl0 < (AW+1)'(DEPTH));
    lvl1   = lvl0 + (AW+1)'(acc_a);
    acc_b  = push_b & (lvl1 < (AW+1)'(DEPTH));
    drop   = (push_a & ~acc_a) | (push_b & ~acc_b);
  end

  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr] <= entry_a;
    if (acc_b) mem[wr_ptr + AW'(acc_a)] <= entry_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= lvl1 + (AW+1)'(acc_b);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: queues bytes/EOP markers, shifts bytes LSB-first
// with bit stuffing and NRZI, emits SE0,SE0,J end-of-packet, idles in J.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] write,
  input  logic       write_enable,
  input  logic       eop_enable,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_ready,
  output logic       overflow
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t  state;
  tx_entry_t  head;
  logic [7:0] shreg;
  logic [2:0] bit_idx, ones_cnt, ones_bit, ones_now;
  logic [1:0] se0_cnt;
  logic [DW-1:0] div;
  logic       level_j, eop_prev, eop_push;
  logic       empty, full, launch, tick, adv, load, pop;

  assign eop_push = eop_enable & ~eop_prev;
  assign tx_ready = ~full;

  tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a   (write_enable),
    .entry_a  ('{is_eop: 1'b0, data: write}),
    .push_b   (eop_push),
    .entry_b  ('{is_eop: 1'b1, data: 8'h00}),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  // A bit is launched onto the lines on the first clock of its bit time and
  // the FSM advances on the last; with CLKS_PER_BIT=1 both coincide.
  always_comb begin
    launch   = (state != ST_IDLE) && (div == '0);
    tick     = (state != ST_IDLE) && (div == DW'(CLKS_PER_BIT - 1));
    ones_bit = shreg[0] ? ones_cnt + 3'd1 : 3'd0;
    ones_now = launch ? ones_bit : ones_cnt;
    adv      = tick && (((state == ST_SHIFT) && (ones_now != 3'(STUFF_LIMIT))) ||
                        (state == ST_STUFF));
    load     = (state == ST_IDLE) || (adv && (bit_idx == 3'd7)) ||
               (tick && (state == ST_EOP_J));
    pop      = load & ~empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      ones_cnt  <= '0;
      se0_cnt   <= '0;
      div       <= '0;
      level_j   <= 1'b1;
      eop_prev  <= 1'b1;
      tx_active <= 1'b0;
      {d_plus, d_minus} <= LINE_J;
    end else begin
      eop_prev  <= eop_enable;
      tx_active <= (state != ST_IDLE);
      div       <= (state == ST_IDLE || tick) ? '0 : div + DW'(1);

      case (state)
        ST_IDLE: begin
          {d_plus, d_minus} <= LINE_J;
          level_j  <= 1'b1;
          ones_cnt <= '0;
        end
        ST_SHIFT: if (launch) begin
          if (!shreg[0]) level_j <= ~level_j;
          {d_plus, d_minus} <= nrzi_line(shreg[0] ? level_j : ~level_j);
          ones_cnt <= ones_bit;
        end
        ST_STUFF: if (launch) begin
          level_j  <= ~level_j;
          {d_plus, d_minus} <= nrzi_line(~level_j);
          ones_cnt <= '0;
        end
        ST_EOP_SE0: if (launch) {d_plus, d_minus} <= LINE_SE0;
        ST_EOP_J: if (launch) begin
          {d_plus, d_minus} <= LINE_J;
          level_j  <= 1'b1;
          ones_cnt <= '0;
        end
        default: ;
      endcase

      if (load) begin
        if (!empty) begin
          if (head.is_eop) begin
            state   <= ST_EOP_SE0;
            se0_cnt <= '0;
          end else begin
            state   <= ST_SHIFT;
            shreg   <= head.data;
            bit_idx <= '0;
          end
        end else begin
          state <= ST_IDLE;
        end
      end else if (tick) begin
        case (state)
          ST_SHIFT: begin
            if (ones_now == 3'(STUFF_LIMIT)) begin
              state <= ST_STUFF;
            end else begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
          ST_STUFF: begin
            state   <= ST_SHIFT;
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
          ST_EOP_SE0: begin
            if (se0_cnt == 2'(EOP_SE0_BITS - 1)) state <= ST_EOP_J;
            else se0_cnt <= se0_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench: line sequences as J/K/0 strings, checked cycle by cycle.
module tb_usb_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] write, write2;
  logic       write_enable, eop_enable, write_enable2, eop_enable2;
  logic       d_plus, d_minus, tx_active, tx_ready, overflow;
  logic       d_plus2, d_minus2, tx_active2, tx_ready2, overflow2;

  int checks = 0;
  int errors = 0;

  usb_tx_serializer #(.DEPTH(4), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .write(write), .write_enable(write_enable),
    .eop_enable(eop_enable), .d_plus(d_plus), .d_minus(d_minus),
    .tx_active(tx_active), .tx_ready(tx_ready), .overflow(overflow)
  );

  usb_tx_serializer #(.DEPTH(4), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .write(write2), .write_enable(write_enable2),
    .eop_enable(eop_enable2), .d_plus(d_plus2), .d_minus(d_minus2),
    .tx_active(tx_active2), .tx_ready(tx_ready2), .overflow(overflow2)
  );

  function automatic logic [7:0] line_ch(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return 8'h4A;  // J
      2'b01:   return 8'h4B;  // K
      2'b00:   return 8'h30;  // SE0
      default: return 8'h58;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input logic with_eop);
    @(negedge clk);
    write = b; write_enable = 1'b1;
    if (with_eop) eop_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // Called at the negedge after the strobe edge N; first bit shows after N+2.
  task automatic expect_seq(input string tag, input string exp, input int skip);
    logic all_act;
    all_act = 1'b1;
    repeat (skip) @(negedge clk);
    for (int i = 0; i < exp.len(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(line_ch(d_plus, d_minus)), 32'(exp[i]));
      all_act &= tx_active;
    end
    check({tag, "_active"}, 32'(all_act), 32'd1);
    @(negedge clk);
    check({tag, "_idle_line"}, 32'(line_ch(d_plus, d_minus)), 32'h4A);
    check({tag, "_idle_act"}, 32'(tx_active), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, bad;
    rst = 1'b1; write = '0; write_enable = 0; eop_enable = 0;
    write2 = '0; write_enable2 = 0; eop_enable2 = 0;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(line_ch(d_plus, d_minus)), 32'h4A);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x00: every bit toggles
    strobe(8'h00, 1'b0);
    expect_seq("b00", "KJKJKJKJ", 1);

    // 0xFF then EOP: stuff after six ones
    strobe(8'hFF, 1'b0);
    eop_enable = 1'b1;
    expect_seq("bFF_eop", "JJJJJJKKK00J", 1);
    eop_enable = 1'b0;
    repeat (2) @(negedge clk);

    // byte and EOP in the same cycle: byte goes first
    strobe(8'h00, 1'b1);
    expect_seq("b00_eop", "KJKJKJKJ00J", 1);
    eop_enable = 1'b0;
    repeat (2) @(negedge clk);

    // lone EOP on an idle line
    @(negedge clk); eop_enable = 1'b1;
    @(negedge clk);
    expect_seq("eop_only", "00J", 1);
    eop_enable = 1'b0;
    repeat (2) @(negedge clk);

    // 0x3F then 0x01 eight cycles later: stuff inside first byte, no gap
    strobe(8'h3F, 1'b0);
    fork
      expect_seq("b3F_01", "JJJJJJKJKKJKJKJKJ", 1);
      begin
        repeat (7) @(negedge clk);
        write = 8'h01; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // 0xE0,0x07 back to back: ones run crosses the byte boundary
    @(negedge clk); write = 8'hE0; write_enable = 1'b1;
    @(negedge clk); write = 8'h07;
    @(negedge clk); write_enable = 1'b0;
    expect_seq("bE0_07", "KJKJKKKKKKKJKJKJK", 0);
    repeat (2) @(negedge clk);

    // six consecutive strobes: one in flight, four queued, sixth dropped
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_active) act++;
      if (i == 5) begin
        check("full_ready", 32'(tx_ready), 32'd0);
        check("full_ovf_pre", 32'(overflow), 32'd0);
      end
      write = 8'h00; write_enable = 1'b1;
    end
    @(negedge clk);
    write_enable = 1'b0;
    if (tx_active) act++;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_ready", 32'(tx_ready), 32'd0);
    repeat (80) begin
      @(negedge clk);
      if (tx_active) act++;
    end
    check("ovf_bits", 32'(act), 32'd40);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_ready_end", 32'(tx_ready), 32'd1);

    // reset during third bit of 0xA5 with more queued and EOP level held high
    @(negedge clk); write = 8'hA5; write_enable = 1'b1;
    @(negedge clk); write = 8'h5A; eop_enable = 1'b1;
    @(negedge clk); write_enable = 1'b0;
    @(negedge clk); check("a5_b0", 32'(line_ch(d_plus, d_minus)), 32'h4A);
    @(negedge clk); check("a5_b1", 32'(line_ch(d_plus, d_minus)), 32'h4B);
    @(negedge clk); check("a5_b2", 32'(line_ch(d_plus, d_minus)), 32'h4B);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_line", 32'(line_ch(d_plus, d_minus)), 32'h4A);
    check("mrst_active", 32'(tx_active), 32'd0);
    check("mrst_ready", 32'(tx_ready), 32'd1);
    check("mrst_ovf", 32'(overflow), 32'd0);
    bad = 0;
    repeat (24) begin
      @(negedge clk);
      if (line_ch(d_plus, d_minus) != 8'h4A || tx_active) bad++;
    end
    check("mrst_quiet", 32'(bad), 32'd0);
    eop_enable = 1'b0;

    // CLKS_PER_BIT=4, byte 0x01: each level held four clocks
    begin
      string exp4;
      logic all_act;
      exp4 = "JKJKJKJK";
      all_act = 1'b1;
      @(negedge clk); write2 = 8'h01; write_enable2 = 1'b1;
      @(negedge clk); write_enable2 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        check($sformatf("cpb4[%0d]", i), 32'(line_ch(d_plus2, d_minus2)), 32'(exp4[i/4]));
        all_act &= tx_active2;
      end
      check("cpb4_active", 32'(all_act), 32'd1);
      @(negedge clk);
      check("cpb4_idle_line", 32'(line_ch(d_plus2, d_minus2)), 32'h4A);
      check("cpb4_idle_act", 32'(tx_active2), 32'd0);
      check("cpb4_ready", 32'(tx_ready2), 32'd1);
      check("cpb4_ovf", 32'(overflow2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
